addsub_seq: RTL and testbench

- Sequencer that owns the 3-bit sign-magnitude add/sub datapath.
- Operand format: bit2 = sign, bits1:0 = magnitude. Result format: bit4 = sign, bit3 = 0, bits2:0 = magnitude.
- Accepts one operation per start strobe, drives the datapath inputs, waits a fixed settle time, then captures result and zero flag into an accumulator register.
- Supports chaining: the previous result becomes operand A. Sits between the calculator input logic and the add_sub datapath.

---
 rtl/addsub_seq_if.sv | 60 ++++++
 rtl/addsub_seq.sv | 146 ++++++++++++++
 tb/tb_addsub_seq.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_if.sv
// -----------------------------------------------------------------------------
// addsub_seq_if
//
// Groups every signal of the add/sub sequencer except clock and reset.
//
// Request side (from the calculator input logic):
//   start, chain, clear   : operation request / chaining / accumulator clear
//   op_a, op_b            : 3-bit sign-magnitude operands (bit2 = sign)
//   sub                   : 0 = A+B, 1 = A-B
// Datapath side (to/from the add_sub datapath):
//   dp_num1, dp_num2      : operands presented to the datapath
//   dp_sel                : add/sub selection presented to the datapath
//   dp_result, dp_zero    : datapath result (bit4 sign, bits2:0 magnitude)
// Status / result side:
//   busy, done, chain_err : sequencer status
//   acc, acc_zero         : accumulated result and its zero flag
//
// Handshake: start is a level sampled only while busy is low. A start seen
// while busy is dropped, not queued. Each accepted start produces exactly one
// single-cycle done pulse; chain_err accompanies done only for a rejected
// chain. Results in acc/acc_zero are valid from the done cycle onward.
//
// Modports:
//   slave  : the sequencer itself
//   master : whoever drives requests and models the datapath
// -----------------------------------------------------------------------------
interface addsub_seq_if;
    logic       start;
    logic       chain;
    logic       clear;
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic       sub;

    logic [2:0] dp_num1;
    logic [2:0] dp_num2;
    logic       dp_sel;
    logic [4:0] dp_result;
    logic       dp_zero;

    logic       busy;
    logic       done;
    logic       chain_err;
    logic [4:0] acc;
    logic       acc_zero;

    modport slave (
        input  start, chain, clear, op_a, op_b, sub,
        input  dp_result, dp_zero,
        output dp_num1, dp_num2, dp_sel,
        output busy, done, chain_err, acc, acc_zero
    );

    modport master (
        output start, chain, clear, op_a, op_b, sub,
        output dp_result, dp_zero,
        input  dp_num1, dp_num2, dp_sel,
        input  busy, done, chain_err, acc, acc_zero
    );
endinterface

// File: rtl/addsub_seq.sv
// -----------------------------------------------------------------------------
// addsub_seq
//
// Sequencer that owns the 3-bit sign-magnitude add/sub datapath. One start
// launches one operation: the operands are registered onto the datapath
// inputs, the block waits SETTLE_CYCLES clock edges for the (slow) datapath
// to settle, then captures its result and zero flag into the accumulator.
// With chain=1 the accumulator replaces op_a, so results can be chained.
// This block does no arithmetic of its own.
//
// Ports:
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   bus          : addsub_seq_if.slave (request, datapath, status signals)
//   dbg_state_o  : current sequencer state (IDLE=0, SETTLE=1, CAPTURE=2,
//                  REJECT=3)
//
// Timing for an accepted operation started at edge E0:
//   E0              : dp_* loaded, busy rises, counter = SETTLE_CYCLES-1
//   E0+SETTLE_CYCLES: acc/acc_zero captured from the datapath
//   following cycle : done=1, busy still 1
//   next edge       : back to IDLE, busy drops
// A rejected chain spends exactly one cycle in REJECT (done=chain_err=1).
// -----------------------------------------------------------------------------
module addsub_seq #(
    parameter int unsigned SETTLE_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    addsub_seq_if.slave bus,
    output logic [1:0]  dbg_state_o
);

    // Counter only has to hold SETTLE_CYCLES-1.
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_REJECT  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       num1_q, num1_d;
    logic [2:0]       num2_q, num2_d;
    logic             sel_q, sel_d;
    logic [4:0]       acc_q, acc_d;
    logic             acc_zero_q, acc_zero_d;

    // A chained operand only has a 2-bit magnitude, so an accumulator whose
    // magnitude is 4..7 (bit2 set) cannot be fed back as operand A.
    logic chain_illegal;
    assign chain_illegal = acc_q[2];

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            num1_q     <= '0;
            num2_q     <= '0;
            sel_q      <= 1'b0;
            acc_q      <= '0;
            acc_zero_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            sel_q      <= sel_d;
            acc_q      <= acc_d;
            acc_zero_q <= acc_zero_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and register-update logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        sel_d      = sel_q;
        acc_d      = acc_q;
        acc_zero_d = acc_zero_q;

        unique case (state_q)
            S_IDLE: begin
                // clear has priority over start; it never produces a done.
                if (bus.clear) begin
                    acc_d      = '0;
                    acc_zero_d = 1'b1;
                end else if (bus.start) begin
                    if (bus.chain && chain_illegal) begin
                        // Operands and accumulator are left untouched.
                        state_d = S_REJECT;
                    end else begin
                        num1_d  = bus.chain ? {acc_q[4], acc_q[1:0]} : bus.op_a;
                        num2_d  = bus.op_b;
                        sel_d   = bus.sub;
                        cnt_d   = CNT_LOAD;
                        state_d = S_SETTLE;
                    end
                end
            end

            S_SETTLE: begin
                if (cnt_q == '0) begin
                    // Zero results are stored as +0 whatever sign the
                    // datapath reports.
                    acc_d      = bus.dp_zero ? 5'b00000 : bus.dp_result;
                    acc_zero_d = bus.dp_zero;
                    state_d    = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_CAPTURE: state_d = S_IDLE;

            S_REJECT:  state_d = S_IDLE;

            default:   state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: status is decoded straight from the state register.
    // -------------------------------------------------------------------------
    assign bus.dp_num1   = num1_q;
    assign bus.dp_num2   = num2_q;
    assign bus.dp_sel    = sel_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_CAPTURE) || (state_q == S_REJECT);
    assign bus.chain_err = (state_q == S_REJECT);
    assign bus.acc       = acc_q;
    assign bus.acc_zero  = acc_zero_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_addsub_seq
//
// Directed bench for addsub_seq. The bench plays the role of the add_sub
// datapath (with a realistic settle delay: outputs are garbage until the
// inputs have been stable long enough) and keeps a timeline model of the
// sequencer that is compared against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_addsub_seq;

    localparam int S = 12;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_seq_if bus();
    logic [1:0] dbg_state;

    addsub_seq #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------- sign-magnitude helpers ----------------
    function automatic int sm3_val(input logic [2:0] v);
        int m;
        m = int'(v[1:0]);
        return v[2] ? -m : m;
    endfunction

    function automatic logic [4:0] sm5_of(input int r);
        int m;
        m = (r < 0) ? -r : r;
        return {(r < 0), 1'b0, m[2:0]};
    endfunction

    // ---------------- datapath model ----------------
    // Output is only valid once dp_* have been stable for S-1 falling edges;
    // before that it shows a wrong value. A zero result keeps num1's sign,
    // so the datapath can report a negative zero.
    int         dp_age;
    logic [6:0] dp_last;
    int         dp_r;
    logic [4:0] dp_res_v;
    logic       dp_zero_v;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_age  = 0;
            dp_last = '0;
        end else if ({bus.dp_num1, bus.dp_num2, bus.dp_sel} != dp_last) begin
            dp_last = {bus.dp_num1, bus.dp_num2, bus.dp_sel};
            dp_age  = 0;
        end else if (dp_age < 1000) begin
            dp_age++;
        end
    end

    always_comb begin
        dp_r      = bus.dp_sel ? sm3_val(bus.dp_num1) - sm3_val(bus.dp_num2)
                               : sm3_val(bus.dp_num1) + sm3_val(bus.dp_num2);
        dp_res_v  = 5'b01010;
        dp_zero_v = 1'b0;
        if (dp_age >= S - 1) begin
            if (dp_r == 0) begin
                dp_res_v  = {bus.dp_num1[2], 4'b0000};
                dp_zero_v = 1'b1;
            end else begin
                dp_res_v  = sm5_of(dp_r);
            end
        end
    end

    assign bus.dp_result = dp_res_v;
    assign bus.dp_zero   = dp_zero_v;

    // ---------------- timeline model / scoreboard ----------------
    // Each accepted operation books its result in exp_q and fixes the edges at
    // which the result lands, done pulses and busy ends.
    logic [5:0] exp_q[$];
    int         cyc, busy_end, cap_at, done_at, err_at;
    logic [4:0] m_acc;
    logic       m_zero;
    logic [2:0] m_dp1, m_dp2, a_sm;
    logic       m_sel;
    logic       exp_busy, exp_done, exp_err;
    int         r;
    logic [5:0] popped;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; busy_end = -1; cap_at = -1; done_at = -1; err_at = -1;
            m_acc = '0; m_zero = 1'b1; m_dp1 = '0; m_dp2 = '0; m_sel = 1'b0;
            exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
            exp_q.delete();
        end else begin
            if (cyc == cap_at && exp_q.size() > 0) begin
                popped = exp_q.pop_front();
                m_zero = popped[5];
                m_acc  = popped[4:0];
            end
            if (cyc > busy_end) begin
                if (bus.clear) begin
                    m_acc  = '0;
                    m_zero = 1'b1;
                end else if (bus.start) begin
                    if (bus.chain && m_acc[2:0] > 3'd3) begin
                        busy_end = cyc + 1;
                        done_at  = cyc;
                        err_at   = cyc;
                    end else begin
                        a_sm  = bus.chain ? {m_acc[4], m_acc[1:0]} : bus.op_a;
                        m_dp1 = a_sm;
                        m_dp2 = bus.op_b;
                        m_sel = bus.sub;
                        r = bus.sub ? sm3_val(a_sm) - sm3_val(bus.op_b)
                                    : sm3_val(a_sm) + sm3_val(bus.op_b);
                        exp_q.push_back({(r == 0), (r == 0) ? 5'b00000 : sm5_of(r)});
                        cap_at   = cyc + S;
                        done_at  = cyc + S;
                        busy_end = cyc + S + 1;
                    end
                end
            end
            exp_busy = (cyc < busy_end);
            exp_done = (cyc == done_at);
            exp_err  = (cyc == err_at);
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",      8'(bus.busy),      8'(exp_busy));
            check("done",      8'(bus.done),      8'(exp_done));
            check("chain_err", 8'(bus.chain_err), 8'(exp_err));
            check("acc",       8'(bus.acc),       8'(m_acc));
            check("acc_zero",  8'(bus.acc_zero),  8'(m_zero));
            check("dp_num1",   8'(bus.dp_num1),   8'(m_dp1));
            check("dp_num2",   8'(bus.dp_num2),   8'(m_dp2));
            check("dp_sel",    8'(bus.dp_sel),    8'(m_sel));
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles", bus.busy, k);
        end
    endtask

    task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic s, input logic c);
        wait_idle();
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        bus.chain = c;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.chain = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < S + 10) begin
            @(negedge clk);
            k++;
        end
        if (k >= S + 10) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", k);
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) cnt++;
        end
    endtask

    task automatic op_check(input string name, input logic [2:0] a, input logic [2:0] b,
                            input logic s, input logic c,
                            input logic [4:0] want_acc, input logic want_zero);
        issue(a, b, s, c);
        wait_done();
        check({name, "_acc"},  8'(bus.acc),      8'(want_acc));
        check({name, "_zero"}, 8'(bus.acc_zero), 8'(want_zero));
    endtask

    // ---------------- directed sequence ----------------
    int nd;

    initial begin
        bus.start = 1'b0; bus.chain = 1'b0; bus.clear = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.sub = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_acc",      8'(bus.acc),      8'h00);
        check("rst_acc_zero", 8'(bus.acc_zero), 8'h01);
        check("rst_busy",     8'(bus.busy),     8'h00);
        check("rst_dp_num1",  8'(bus.dp_num1),  8'h00);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // 2 + 1 = 3; operands reach the datapath one edge after start
        issue(3'b010, 3'b001, 1'b0, 1'b0);
        check("load_dp_num1", 8'(bus.dp_num1), 8'h02);
        check("load_dp_num2", 8'(bus.dp_num2), 8'h01);
        check("load_dp_sel",  8'(bus.dp_sel),  8'h00);
        wait_done();
        check("add_acc",  8'(bus.acc),      8'b00011);
        check("add_zero", 8'(bus.acc_zero), 8'h00);

        // 1 - 3 = -2, then chained -2 + 1 = -1
        op_check("sub_neg", 3'b001, 3'b011, 1'b1, 1'b0, 5'b10010, 1'b0);
        issue(3'b000, 3'b001, 1'b0, 1'b1);
        check("chain_dp_num1", 8'(bus.dp_num1), 8'b110);
        wait_done();
        check("chain_acc", 8'(bus.acc), 8'b10001);

        // zero results, including a datapath negative zero
        op_check("zero_pos", 3'b010, 3'b010, 1'b1, 1'b0, 5'b00000, 1'b1);
        op_check("zero_neg", 3'b110, 3'b110, 1'b1, 1'b0, 5'b00000, 1'b1);

        // chaining from magnitude 3 is still legal
        op_check("min3",      3'b111, 3'b000, 1'b0, 1'b0, 5'b10011, 1'b0);
        op_check("chain_m3",  3'b000, 3'b001, 1'b0, 1'b1, 5'b10010, 1'b0);

        // 3 + 3 = 6, then a chain must be rejected
        op_check("add6", 3'b011, 3'b011, 1'b0, 1'b0, 5'b00110, 1'b0);
        issue(3'b000, 3'b001, 1'b0, 1'b1);
        check("rej_done",  8'(bus.done),      8'h01);
        check("rej_err",   8'(bus.chain_err), 8'h01);
        check("rej_busy",  8'(bus.busy),      8'h01);
        check("rej_acc",   8'(bus.acc),       8'b00110);
        @(negedge clk);
        check("rej_busy_drop", 8'(bus.busy), 8'h00);

        // start and clear pulsed during SETTLE are ignored
        issue(3'b111, 3'b010, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.clear = 1'b1; bus.op_a = 3'b001;
        @(negedge clk);
        bus.start = 1'b0; bus.clear = 1'b0;
        wait_done();
        check("busy_ign_acc", 8'(bus.acc), 8'b10001);
        count_dones(20, nd);
        check("busy_ign_one_done", 8'(nd), 8'h00);

        // clear and start together in IDLE: clear wins, no done
        wait_idle();
        bus.clear = 1'b1; bus.start = 1'b1; bus.op_a = 3'b011; bus.op_b = 3'b001;
        @(negedge clk);
        bus.clear = 1'b0; bus.start = 1'b0;
        check("clr_acc",  8'(bus.acc),      8'h00);
        check("clr_zero", 8'(bus.acc_zero), 8'h01);
        count_dones(S + 4, nd);
        check("clr_no_done", 8'(nd), 8'h00);

        // -1 - 3 = -4
        op_check("sub_m4", 3'b101, 3'b011, 1'b1, 1'b0, 5'b10100, 1'b0);

        // reset in the middle of SETTLE aborts the operation
        issue(3'b011, 3'b010, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 8'(bus.busy),     8'h00);
        check("mid_rst_acc",  8'(bus.acc),      8'h00);
        check("mid_rst_zero", 8'(bus.acc_zero), 8'h01);
        @(negedge clk);
        #2 rst_n = 1'b1;
        count_dones(S + 6, nd);
        check("mid_rst_no_done", 8'(nd), 8'h00);
        check("mid_rst_acc_after", 8'(bus.acc), 8'h00);

        // normal operation resumes after reset
        op_check("post_rst", 3'b001, 3'b001, 1'b0, 1'b0, 5'b00010, 1'b0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
